// File: rtl/ifetch_queue.sv
// Instruction fetch queue: streams words from instruction memory into a small FIFO
// and presents 1-word or 3-word (inst + 64-bit immediate) packets to the decoder.
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        im_rvalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_imm,
    output logic        out_imm_en,
    output logic [31:0] out_pc
);

    // Handshakes: im_req is accepted every cycle it is high and its word returns on
    // im_rvalid exactly one cycle later; a packet transfers when out_valid & out_ready.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [0:0]    state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   out_pc_q, out_pc_d;

    logic [31:0]   head;
    logic [31:0]   imm_lo;
    logic [31:0]   imm_hi;
    logic          head_is3;
    logic [CW-1:0] pkt_words;
    logic [CW:0]   occupancy;
    logic          outstanding;
    logic          push;
    logic          drop_word;
    logic          fire;
    logic [31:0]   redirect_aligned;
    logic          unused_pc_bits;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + (PW + 1)'(n);
        if (s >= (PW + 1)'(DEPTH)) begin
            s = s - (PW + 1)'(DEPTH);
        end
        return s[PW-1:0];
    endfunction

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits   = ^redirect_pc[1:0];

    always_comb begin
        head      = mem_q[rd_ptr_q];
        imm_lo    = mem_q[ptr_add(rd_ptr_q, 2'd1)];
        imm_hi    = mem_q[ptr_add(rd_ptr_q, 2'd2)];
        head_is3  = head[3];
        pkt_words = head_is3 ? CW'(3) : CW'(1);
    end

    // A word still outstanding is one issued earlier whose im_rvalid has not yet arrived.
    assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign outstanding = inflight_q & ~im_rvalid;

    assign im_req  = ~reset & ~redirect & (state_q == ST_RUN) & ~outstanding &
                     (occupancy < (CW + 1)'(DEPTH));
    assign im_addr = fpc_q;

    assign out_valid  = (count_q >= pkt_words);
    assign out_inst   = head;
    assign out_imm_en = head[3];
    assign out_imm    = head_is3 ? {imm_hi, imm_lo} : 64'd0;
    assign out_pc     = out_pc_q;

    assign fire      = out_valid & out_ready;
    assign push      = im_rvalid & inflight_q & (state_q == ST_RUN) & ~redirect;
    assign drop_word = im_rvalid & inflight_q & (state_q == ST_DROP);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        state_d    = state_q;
        fpc_d      = fpc_q;
        out_pc_d   = out_pc_q;

        if (redirect) begin
            // A coincident handshake is simply absorbed by the flush.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fpc_d      = redirect_aligned;
            out_pc_d   = redirect_aligned;
            inflight_d = outstanding;
            state_d    = outstanding ? ST_DROP : ST_RUN;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = im_rdata;
                wr_ptr_d        = ptr_add(wr_ptr_q, 2'd1);
            end
            if (fire) begin
                rd_ptr_d = ptr_add(rd_ptr_q, head_is3 ? 2'd3 : 2'd1);
                out_pc_d = out_pc_q + (head_is3 ? 32'd12 : 32'd4);
            end
            count_d = count_q + CW'(push) - (fire ? pkt_words : CW'(0));

            if (im_req) begin
                fpc_d      = fpc_q + 32'd4;
                inflight_d = 1'b1;
            end else if (im_rvalid) begin
                inflight_d = 1'b0;
            end

            if (drop_word) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            state_q    <= ST_RUN;
            fpc_q      <= '0;
            out_pc_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            out_pc_q   <= out_pc_d;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a cycle table from reset plus hand-written
// sequences for backpressure, redirect, address wrap and mid-packet reset.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata = '0;
    logic        im_rvalid = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_imm;
    logic        out_imm_en;
    logic [31:0] out_pc;

    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc_q [$];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        logic        exp_en;
        logic [63:0] exp_imm;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .im_rvalid   (im_rvalid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_imm     (out_imm),
        .out_imm_en  (out_imm_en),
        .out_pc      (out_pc)
    );

    // Memory returns the addressed word one cycle after each request.
    always @(posedge clk) begin
        im_rvalid <= im_req;
        im_rdata  <= mem[im_addr[9:2]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic fill_default();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0100_0000 | (32'(i) << 4);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        #1;
        while (!out_valid && k < budget) begin
            step();
            #1;
            k++;
        end
        check(name, 64'(out_valid), 64'd1);
    endtask

    function automatic vec_t mk(input logic rq, input logic [31:0] a, input logic vl,
                                input logic [31:0] inst, input logic [31:0] pc,
                                input logic en, input logic [63:0] imm);
        vec_t v;
        v.ready     = 1'b1;
        v.exp_req   = rq;
        v.exp_addr  = a;
        v.exp_valid = vl;
        v.exp_inst  = inst;
        v.exp_pc    = pc;
        v.exp_en    = en;
        v.exp_imm   = imm;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------------- cycle table from reset, decoder always ready ----------------
        fill_default();
        mem[0] = 32'h0000_0011;
        mem[1] = 32'h0000_0022;
        mem[2] = 32'h0000_0108;
        mem[3] = 32'hDEAD_BEEF;
        mem[4] = 32'h0123_4567;
        mem[5] = 32'h0000_0044;
        mem[6] = 32'h0000_0055;
        tbl[0] = mk(1'b1, 32'h00, 1'b0, 32'h0,   32'h0,  1'b0, 64'h0);
        tbl[1] = mk(1'b1, 32'h04, 1'b0, 32'h0,   32'h0,  1'b0, 64'h0);
        tbl[2] = mk(1'b1, 32'h08, 1'b1, 32'h11,  32'h0,  1'b0, 64'h0);
        tbl[3] = mk(1'b1, 32'h0C, 1'b1, 32'h22,  32'h4,  1'b0, 64'h0);
        tbl[4] = mk(1'b1, 32'h10, 1'b0, 32'h0,   32'h0,  1'b0, 64'h0);
        tbl[5] = mk(1'b1, 32'h14, 1'b0, 32'h0,   32'h0,  1'b0, 64'h0);
        tbl[6] = mk(1'b0, 32'h00, 1'b1, 32'h108, 32'h8,  1'b1, 64'h0123_4567_DEAD_BEEF);
        tbl[7] = mk(1'b1, 32'h18, 1'b1, 32'h44,  32'h14, 1'b0, 64'h0);
        tbl[8] = mk(1'b1, 32'h1C, 1'b0, 32'h0,   32'h0,  1'b0, 64'h0);
        tbl[9] = mk(1'b1, 32'h20, 1'b1, 32'h55,  32'h18, 1'b0, 64'h0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            out_ready = tbl[i].ready;
            #1;
            check($sformatf("tbl%0d im_req", i), 64'(im_req), 64'(tbl[i].exp_req));
            if (tbl[i].exp_req) check($sformatf("tbl%0d im_addr", i), 64'(im_addr), 64'(tbl[i].exp_addr));
            check($sformatf("tbl%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d out_inst", i), 64'(out_inst), 64'(tbl[i].exp_inst));
                check($sformatf("tbl%0d out_pc", i), 64'(out_pc), 64'(tbl[i].exp_pc));
                check($sformatf("tbl%0d out_imm_en", i), 64'(out_imm_en), 64'(tbl[i].exp_en));
                check($sformatf("tbl%0d out_imm", i), out_imm, tbl[i].exp_imm);
            end
            step();
        end

        // ---------------- backpressure: decoder stalls for 10 cycles ----------------
        begin
            int nreq;
            fill_default();
            do_reset();
            nreq = 0;
            for (int c = 0; c < 10; c++) begin
                #1;
                if (im_req) nreq++;
                if (c >= 2) begin
                    check("bp out_valid", 64'(out_valid), 64'd1);
                    check("bp out_inst stable", 64'(out_inst), 64'(mem[0]));
                    check("bp out_pc stable", 64'(out_pc), 64'd0);
                end
                step();
            end
            #1;
            check("bp request count", 64'(nreq), 64'(DEPTH));
            check("bp im_req idle", 64'(im_req), 64'd0);
            for (int j = 0; j < 8; j++) begin
                exp_q.push_back(mem[j]);
                exp_pc_q.push_back(32'(j * 4));
            end
            out_ready = 1'b1;
            for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
                if (out_valid) begin
                    check("bp drain inst", 64'(out_inst), 64'(exp_q.pop_front()));
                    check("bp drain pc", 64'(out_pc), 64'(exp_pc_q.pop_front()));
                end
                step();
                #1;
            end
            check("bp drained", 64'(exp_q.size()), 64'd0);
        end

        // ---------------- redirect mid 3-word packet with a word in flight ----------------
        fill_default();
        mem[0]    = 32'h0000_0108;
        mem[1]    = 32'hDEAD_BEEF;
        mem[2]    = 32'h0123_4567;
        mem[8'h80] = 32'h0000_0A10;
        mem[8'h81] = 32'h0000_0B20;
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        #1;
        check("rd im_req during redirect", 64'(im_req), 64'd0);
        check("rd partial packet hidden", 64'(out_valid), 64'd0);
        step();
        redirect = 1'b0;
        #1;
        check("rd out_valid after redirect", 64'(out_valid), 64'd0);
        check("rd im_req resumes", 64'(im_req), 64'd1);
        check("rd im_addr", 64'(im_addr), 64'h200);
        step();
        wait_valid("rd first packet valid", 10);
        check("rd first inst", 64'(out_inst), 64'h0A10);
        check("rd first pc", 64'(out_pc), 64'h200);
        check("rd first imm_en", 64'(out_imm_en), 64'd0);
        step();
        #1;
        check("rd second valid", 64'(out_valid), 64'd1);
        check("rd second inst", 64'(out_inst), 64'h0B20);
        check("rd second pc", 64'(out_pc), 64'h204);

        // ---------------- redirect on a handshake, then address wrap ----------------
        fill_default();
        mem[0]     = 32'h0000_0011;
        mem[8'hFF] = 32'h0000_0F00;
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        #1;
        check("wr handshake valid", 64'(out_valid), 64'd1);
        check("wr handshake pc", 64'(out_pc), 64'd0);
        step();
        redirect = 1'b0;
        #1;
        check("wr valid after redirect", 64'(out_valid), 64'd0);
        check("wr im_req", 64'(im_req), 64'd1);
        check("wr im_addr top", 64'(im_addr), 64'hFFFF_FFFC);
        step();
        #1;
        check("wr im_req wrapped", 64'(im_req), 64'd1);
        check("wr im_addr wrapped", 64'(im_addr), 64'h0);
        step();
        #1;
        check("wr top valid", 64'(out_valid), 64'd1);
        check("wr top inst", 64'(out_inst), 64'h0F00);
        check("wr top pc", 64'(out_pc), 64'hFFFF_FFFC);
        step();
        #1;
        check("wr wrap valid", 64'(out_valid), 64'd1);
        check("wr wrap inst", 64'(out_inst), 64'h11);
        check("wr wrap pc", 64'(out_pc), 64'h0);

        // ---------------- reset between imm-low and imm-high fetches ----------------
        fill_default();
        mem[0] = 32'h0000_0108;
        mem[1] = 32'hDEAD_BEEF;
        mem[2] = 32'h0123_4567;
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst im_req", 64'(im_req), 64'd0);
        check("rst out_inst", 64'(out_inst), 64'd0);
        check("rst out_imm", out_imm, 64'd0);
        check("rst out_imm_en", 64'(out_imm_en), 64'd0);
        check("rst out_pc", 64'(out_pc), 64'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst release im_req", 64'(im_req), 64'd1);
        check("rst release im_addr", 64'(im_addr), 64'd0);
        check("rst release out_pc", 64'(out_pc), 64'd0);
        check("rst release out_valid", 64'(out_valid), 64'd0);
        step();
        wait_valid("rst packet valid", 10);
        check("rst packet inst", 64'(out_inst), 64'h108);
        check("rst packet imm", out_imm, 64'h0123_4567_DEAD_BEEF);
        check("rst packet imm_en", 64'(out_imm_en), 64'd1);
        check("rst packet pc", 64'(out_pc), 64'd0);
        step();
        wait_valid("rst next valid", 10);
        check("rst next pc", 64'(out_pc), 64'd12);
        check("rst next inst", 64'(out_inst), 64'(mem[3]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, word-FIFO entries; legal range 3..16.
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port redirect  input  1  flush the queue and restart fetch at redirect_pc.
REQ-005 SHALL have port redirect_pc  input  32  new fetch byte address; bits [1:0] are ignored.
REQ-006 SHALL have port im_req  output  1  instruction-memory word read request.
REQ-007 SHALL have port im_addr  output  32  word-aligned byte address of the request.
REQ-008 SHALL have port im_rdata  input  32  read word, little-endian byte order.
REQ-009 SHALL have port im_rvalid  input  1  high exactly one cycle after each accepted im_req.
REQ-010 SHALL have port out_valid  output  1  a complete instruction packet is presented.
REQ-011 SHALL have port out_ready  input  1  decoder accepts the packet.
REQ-012 SHALL have port out_inst  output  32  instruction word.
REQ-013 SHALL have port out_imm  output  64  immediate value; zero when out_imm_en=0.
REQ-014 SHALL have port out_imm_en  output  1  equals out_inst[3].
REQ-015 SHALL have port out_pc  output  32  byte address of out_inst.

Function
REQ-016 SHALL keep a fetch pointer fpc; every im_req issues with im_addr=fpc, and fpc then advances by 4, wrapping mod 2^32.
REQ-017 SHALL drive im_req combinationally high only when all of the following hold: FIFO occupancy plus in-flight requests < DEPTH, redirect=0, and reset=0.
REQ-018 SHALL allow at most one request in flight and SHALL push im_rdata into the FIFO on each im_rvalid, unless that word is being dropped (see REQ-024).
REQ-019 SHALL treat the FIFO head word as the instruction; if head[3]=1 the packet is 3 words (inst, imm[31:0], imm[63:32]), otherwise it is 1 word.
REQ-020 SHALL assert out_valid only when the FIFO holds every word of the head packet; out_inst, out_imm and out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 SHALL pop 1 or 3 words on a handshake (out_valid & out_ready) and advance out_pc by 4 or 12 respectively, wrapping mod 2^32.
REQ-022 SHALL, in the same cycle, support a push and a pop without loss or duplication.
REQ-023 SHALL give a first out_valid 2 cycles after the first im_req for a 1-word instruction: request at edge N, data at edge N+1, out_valid high after edge N+1.
REQ-024 SHALL implement a 2-state FSM, RUN and DROP.
  - Redirect: redirect=1 in RUN or DROP empties the FIFO and sets fpc = out_pc = {redirect_pc[31:2],2'b00}.
  - Next state after redirect: DROP if a request was in flight, else RUN.
  - DROP discards the next im_rvalid word, then returns to RUN.
REQ-025 SHALL, when redirect coincides with a handshake, count the handshake as consumed and still flush; redirect has priority over push.
REQ-026 SHALL hold out_valid=0 in the cycle after a redirect.
REQ-027 SHALL NOT present a partial 3-word packet; if the packet is split across a redirect, it is discarded.

Reset
REQ-028 SHALL, on reset assertion, immediately and asynchronously clear:
  - FIFO pointers, count and storage; in-flight flag; state to RUN.
  - fpc=0 and out_pc=0.
  - Outputs: out_valid=0, im_req=0, out_inst=0, out_imm=0, out_imm_en=0.
REQ-029 SHALL, after reset deasserts, issue im_req with im_addr=0 in the first clock cycle.
REQ-030 SHALL, when reset is asserted mid-packet or mid-request, discard all state; a late im_rvalid during reset SHALL be ignored.

Verification
REQ-031 SHALL cover: memory words 0x00000011, 0x00000022 at 0x0/0x4, out_ready=1 -> packets inst=0x11 pc=0, then inst=0x22 pc=4, out_imm_en=0, out_imm=0.
REQ-032 SHALL cover: words 0x00000108, 0xDEADBEEF, 0x01234567 at 0x0 -> a single packet inst=0x108, imm=0x01234567DEADBEEF, imm_en=1, pc=0; the next packet has pc=12.
REQ-033 SHALL cover: out_ready=0 for 10 cycles -> im_req stops after DEPTH words are buffered; out_inst stays stable; no word is lost when out_ready rises.
REQ-034 SHALL cover: redirect=1 with redirect_pc=0x203 while a request is in flight -> the stale word is dropped; next im_addr=0x200; first packet pc=0x200.
REQ-035 SHALL cover: fpc=0xFFFFFFFC -> the next im_addr=0x00000000.
REQ-036 SHALL cover: reset asserted between the imm-low and imm-high fetches -> out_valid=0 immediately; after release im_addr=0 and out_pc=0.
